// File: rtl/lif_node_array.sv
// Parametrised leaky integrate-and-fire node: sums N_IN unsigned channels into a saturating,
// leaking membrane potential, fires a registered spike at a runtime threshold, then refracts.
module lif_node_array #(
  parameter int unsigned N_IN        = 4,
  parameter int unsigned IN_W        = 4,
  parameter int unsigned POT_W       = 8,
  parameter int unsigned OUT_W       = 4,
  parameter int unsigned LEAK_SHIFT  = 2,
  parameter int unsigned REFRACT_CYC = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_IN*IN_W-1:0]   in_bus,
  input  logic [POT_W-1:0]       thr,
  input  logic                   en,
  output logic [OUT_W-1:0]       out,
  output logic                   spike,
  output logic                   refractory
);

  localparam int unsigned SUM_W  = IN_W + $clog2(N_IN) + 1;
  localparam int unsigned FULL_W = ((POT_W > SUM_W) ? POT_W : SUM_W) + 1;
  localparam int unsigned CNT_W  = (REFRACT_CYC > 0) ? $clog2(REFRACT_CYC + 1) : 1;

  localparam logic [FULL_W-1:0] SAT_MAX = {{(FULL_W - POT_W){1'b0}}, {POT_W{1'b1}}};

  if (OUT_W > POT_W || OUT_W < 1 || N_IN < 1) begin : g_param_check
    $fatal(1, "lif_node_array: illegal OUT_W/POT_W/N_IN combination");
  end

  typedef enum logic [0:0] {StIntegrate, StRefract} state_e;

  state_e             state_q;
  logic [POT_W-1:0]   v_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               spike_q;
  logic               refr_q;

  logic [SUM_W-1:0]   sum;
  logic [POT_W-1:0]   leak;
  logic [FULL_W-1:0]  vn_full;
  logic [POT_W-1:0]   vn;
  logic               fire;

  always_comb begin
    sum = '0;
    for (int i = 0; i < N_IN; i++) begin
      sum = sum + SUM_W'(in_bus[i*IN_W +: IN_W]);
    end
  end

  // Floor shift keeps V - leak non-negative; a shift past the width means no leak at all.
  always_comb begin
    leak = '0;
    if (LEAK_SHIFT < POT_W) begin
      leak = v_q >> LEAK_SHIFT;
    end
    vn_full = FULL_W'(v_q) - FULL_W'(leak) + FULL_W'(sum);
    vn      = (vn_full > SAT_MAX) ? {POT_W{1'b1}} : vn_full[POT_W-1:0];
    fire    = (vn >= thr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIntegrate;
      v_q     <= '0;
      cnt_q   <= '0;
      spike_q <= 1'b0;
      refr_q  <= 1'b0;
    end else if (!en) begin
      spike_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIntegrate: begin
          if (fire) begin
            v_q     <= '0;
            spike_q <= 1'b1;
            if (REFRACT_CYC > 0) begin
              state_q <= StRefract;
              cnt_q   <= CNT_W'(REFRACT_CYC);
              refr_q  <= 1'b1;
            end
          end else begin
            v_q     <= vn;
            spike_q <= 1'b0;
          end
        end
        StRefract: begin
          v_q     <= '0;
          spike_q <= 1'b0;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= StIntegrate;
            cnt_q   <= '0;
            refr_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= StIntegrate;
        end
      endcase
    end
  end

  assign out        = v_q[POT_W-1 -: OUT_W];
  assign spike      = spike_q;
  assign refractory = refr_q;

endmodule

// File: tb/tb_lif_node_array.sv
// Self-checking bench for lif_node_array: directed tables, corner sequences and a randomized
// run against an integer reference model, on three parameterisations sharing one stimulus.
module tb_lif_node_array;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_bus;
  logic [7:0]  thr;
  logic        en;

  logic [3:0] out_a, out_b, out_c;
  logic       spike_a, spike_b, spike_c;
  logic       refr_a, refr_b, refr_c;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Defaults.
  lif_node_array u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .thr(thr), .en(en),
    .out(out_a), .spike(spike_a), .refractory(refr_a)
  );

  // No leak.
  lif_node_array #(.LEAK_SHIFT(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .thr(thr), .en(en),
    .out(out_b), .spike(spike_b), .refractory(refr_b)
  );

  // No refractory period.
  lif_node_array #(.REFRACT_CYC(0)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .thr(thr), .en(en),
    .out(out_c), .spike(spike_c), .refractory(refr_c)
  );

  // Reference model: cnt > 0 means the node is refracting.
  typedef struct {
    int v;
    int cnt;
    bit spike;
  } model_t;

  model_t ma, mb, mc;

  function automatic model_t step(model_t m, int ls, int rc, int sum, int th, bit e);
    int vn;
    if (!e) begin
      m.spike = 0;
      return m;
    end
    if (m.cnt > 0) begin
      m.cnt   = m.cnt - 1;
      m.v     = 0;
      m.spike = 0;
      return m;
    end
    vn = m.v - ((ls >= 8) ? 0 : (m.v / (1 << ls))) + sum;
    if (vn > 255) vn = 255;
    if (vn >= th) begin
      m.v     = 0;
      m.spike = 1;
      m.cnt   = rc;
    end else begin
      m.v     = vn;
      m.spike = 0;
    end
    return m;
  endfunction

  function automatic int sum_of(logic [15:0] b);
    return int'(b[3:0]) + int'(b[7:4]) + int'(b[11:8]) + int'(b[15:12]);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    ma = '{0, 0, 0};
    mb = '{0, 0, 0};
    mc = '{0, 0, 0};
  endtask

  task automatic set_in(input int val);
    logic [3:0] nib;
    nib    = val[3:0];
    in_bus = {4{nib}};
  endtask

  task automatic check_model(input string tag, input model_t m, input logic [3:0] o,
                             input logic s, input logic r);
    check({tag, " out"}, int'(o), m.v / 16);
    check({tag, " spike"}, int'(s), int'(m.spike));
    check({tag, " refractory"}, int'(r), int'(m.cnt > 0));
  endtask

  typedef struct {
    bit rst;
    bit en;
    int val;
    int th;
    int eo;
    int es;
    int er;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n  = 1'b0;
    in_bus = '0;
    thr    = '0;
    en     = 1'b0;
    #2;
    check("reset out", int'(out_a), 0);
    check("reset spike", int'(spike_a), 0);
    check("reset refractory", int'(refr_a), 0);
    rst_n = 1'b1;
    #20;

    // Fire, 3-cycle refractory, resume; then the same with en dropped before and during refract.
    tbl.push_back('{1, 1, 4, 20, 1, 0, 0});
    tbl.push_back('{0, 1, 4, 20, 0, 1, 1});
    tbl.push_back('{0, 1, 4, 20, 0, 0, 1});
    tbl.push_back('{0, 1, 4, 20, 0, 0, 1});
    tbl.push_back('{0, 1, 4, 20, 0, 0, 0});
    tbl.push_back('{0, 1, 4, 20, 1, 0, 0});
    tbl.push_back('{0, 1, 4, 20, 0, 1, 1});
    tbl.push_back('{1, 1, 4, 20, 1, 0, 0});
    tbl.push_back('{0, 0, 4, 20, 1, 0, 0});
    tbl.push_back('{0, 0, 4, 20, 1, 0, 0});
    tbl.push_back('{0, 1, 4, 20, 0, 1, 1});
    tbl.push_back('{0, 1, 4, 20, 0, 0, 1});
    tbl.push_back('{0, 0, 4, 20, 0, 0, 1});
    tbl.push_back('{0, 0, 4, 20, 0, 0, 1});
    tbl.push_back('{0, 1, 4, 20, 0, 0, 1});
    tbl.push_back('{0, 1, 4, 20, 0, 0, 0});
    tbl.push_back('{0, 1, 4, 20, 1, 0, 0});

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      set_in(tbl[i].val);
      thr = 8'(tbl[i].th);
      en  = tbl[i].en;
      tick();
      check($sformatf("tbl[%0d] out", i), int'(out_a), tbl[i].eo);
      check($sformatf("tbl[%0d] spike", i), int'(spike_a), tbl[i].es);
      check($sformatf("tbl[%0d] refractory", i), int'(refr_a), tbl[i].er);
    end

    // No leak: 60,120,180,240 then 300 saturates to 255 and fires at thr=255.
    // Same stimulus on the leaky node converges near 240 and never fires.
    do_reset();
    set_in(15);
    thr = 8'd255;
    en  = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k <= 4) begin
        check($sformatf("noleak out edge%0d", k), int'(out_b), (60 * k) / 16);
        check($sformatf("noleak spike edge%0d", k), int'(spike_b), 0);
      end else if (k == 5) begin
        check("noleak saturate spike", int'(spike_b), 1);
        check("noleak saturate out", int'(out_b), 0);
      end
      check($sformatf("leak nofire edge%0d", k), int'(spike_a), 0);
    end
    check("leak converged out", int'(out_a), 15);

    // No refractory: thr=0 with zero input fires every edge.
    do_reset();
    set_in(0);
    thr = 8'd0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("r0 spike edge%0d", k), int'(spike_c), 1);
      check($sformatf("r0 refractory edge%0d", k), int'(refr_c), 0);
    end

    // Asynchronous reset between edges while spiking and refracting.
    do_reset();
    set_in(4);
    thr = 8'd20;
    tick();
    tick();
    check("pre-reset spike", int'(spike_a), 1);
    check("pre-reset refractory", int'(refr_a), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset spike", int'(spike_a), 0);
    check("async reset refractory", int'(refr_a), 0);
    check("async reset out", int'(out_a), 0);
    #1;
    rst_n = 1'b1;
    tick();
    check("post-reset out", int'(out_a), 1);
    check("post-reset spike", int'(spike_a), 0);
    check("post-reset refractory", int'(refr_a), 0);

    // Randomized run against the model on all three nodes.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      int s;
      in_bus = 16'($urandom);
      thr    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 16)) : 8'($urandom);
      en     = ($urandom_range(0, 4) != 0);
      s      = sum_of(in_bus);
      tick();
      ma = step(ma, 2, 3, s, int'(thr), en);
      mb = step(mb, 8, 3, s, int'(thr), en);
      mc = step(mc, 2, 0, s, int'(thr), en);
      check_model($sformatf("rand%0d a", k), ma, out_a, spike_a, refr_a);
      check_model($sformatf("rand%0d b", k), mb, out_b, spike_b, refr_b);
      check_model($sformatf("rand%0d c", k), mc, out_c, spike_c, refr_c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
